floor_request_scheduler: RTL and testbench

Collects floor call-button presses, latches them as pending calls and drives the `requested_floor` target into the elevator state machine. It reads back `current_floor` to detect arrival, clears served calls and holds a door dwell period before moving on. Targets follow SCAN ordering: keep the travel direction while calls remain ahead, then reverse. It sits between the `ui_in` button pins and the elevator FSM, upstream of the 7-segment path.

---
 rtl/floor_request_scheduler.sv | 125 ++++++++++++
 tb/tb_floor_request_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: latches floor calls and dispatches SCAN-ordered targets to the elevator FSM
module floor_request_scheduler #(
  parameter int          NUM_FLOORS  = 10,
  parameter logic [31:0] DWELL_COUNT = 32'd10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_buttons,
  input  logic [3:0]            current_floor,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up
);
  typedef enum logic [1:0] {IDLE, SERVING, DWELL} state_t;
  state_t state, state_nx;
  logic [NUM_FLOORS-1:0] sync1, sync2, prev, press, cf_mask, clr, pending_nx;
  logic [3:0] up_t, dn_t, ahead_t, back_t, tgt, req_nx;
  logic up_v, dn_v, ahead_v, back_v, here, cf_ok, tgt_v, flip, door_nx, dir_nx;
  logic [31:0] cnt, cnt_nx;
  assign press = sync2 & ~prev;
  // two-flop synchronizer plus registered copy for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= call_buttons;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end
  // nearest pending call above and below the current floor; empty mask means floor out of range
  always_comb begin
    up_v    = 1'b0;
    up_t    = 4'd0;
    dn_v    = 1'b0;
    dn_t    = 4'd0;
    cf_mask = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      cf_mask[i] = 4'(i) == current_floor;
      if (pending[i] && 4'(i) > current_floor) begin
        up_v = 1'b1;
        up_t = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && 4'(i) < current_floor) begin
        dn_v = 1'b1;
        dn_t = 4'(i);
      end
    cf_ok   = |cf_mask;
    here    = |(pending & cf_mask);
    ahead_v = dir_up ? up_v : dn_v;
    ahead_t = dir_up ? up_t : dn_t;
    back_v  = dir_up ? dn_v : up_v;
    back_t  = dir_up ? dn_t : up_t;
    tgt_v   = cf_ok & (here | ahead_v | back_v);
    tgt     = here ? current_floor : ahead_v ? ahead_t : back_t;
    flip    = ~here & ~ahead_v & back_v;
  end
  // scheduler next state: dispatch, en-route retarget, arrival and door dwell
  always_comb begin
    state_nx = state;
    req_nx   = requested_floor;
    dir_nx   = dir_up;
    door_nx  = door_open;
    cnt_nx   = cnt;
    clr      = '0;
    case (state)
      IDLE:
        if (tgt_v && here) begin
          clr      = cf_mask;
          door_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = DWELL;
        end else if (tgt_v) begin
          req_nx   = tgt;
          dir_nx   = flip ? ~dir_up : dir_up;
          state_nx = SERVING;
        end
      SERVING:
        if (current_floor == requested_floor) begin
          clr      = cf_mask;
          door_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = DWELL;
        end else if (cf_ok && (dir_up ? current_floor < requested_floor : current_floor > requested_floor)) begin
          if (here)
            req_nx = current_floor;
          else if (ahead_v && (dir_up ? ahead_t < requested_floor : ahead_t > requested_floor))
            req_nx = ahead_t;
        end
      DWELL:
        if (|(press & cf_mask))
          cnt_nx = '0;
        else if (cnt == DWELL_COUNT - 32'd1) begin
          door_nx  = 1'b0;
          state_nx = IDLE;
        end else
          cnt_nx = cnt + 32'd1;
      default: state_nx = IDLE;
    endcase
    pending_nx = (pending | (press & ~(state == DWELL ? cf_mask : '0))) & ~clr;
  end
  // scheduler state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      requested_floor <= 4'd0;
      pending         <= '0;
      door_open       <= 1'b0;
      dir_up          <= 1'b1;
      cnt             <= '0;
    end else begin
      state           <= state_nx;
      requested_floor <= req_nx;
      pending         <= pending_nx;
      door_open       <= door_nx;
      dir_up          <= dir_nx;
      cnt             <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: vector table and scoreboard bench for the floor scheduler
module tb_floor_request_scheduler;
  localparam int NF = 10;
  localparam logic [31:0] DW = 32'd4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NF-1:0] btn = '0;
  logic [3:0] cf = 4'd0;
  logic [3:0] requested_floor;
  logic [NF-1:0] pending;
  logic door_open, dir_up;
  typedef struct {
    logic [NF-1:0] b;
    logic [3:0]    c;
    logic [3:0]    r;
    logic [NF-1:0] p;
    logic          d;
    logic          u;
  } vec_t;
  typedef struct {
    string         name;
    logic [3:0]    r;
    logic [NF-1:0] p;
    logic          d;
    logic          u;
  } exp_t;
  exp_t sb[$];
  vec_t basic[11];
  int checks = 0;
  int failures = 0;
  floor_request_scheduler #(.NUM_FLOORS(NF), .DWELL_COUNT(DW)) dut (
    .clk(clk),
    .reset(reset),
    .call_buttons(btn),
    .current_floor(cf),
    .requested_floor(requested_floor),
    .pending(pending),
    .door_open(door_open),
    .dir_up(dir_up)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask
  task automatic step(input string n, input logic [NF-1:0] b, input logic [3:0] c,
                      input logic [3:0] r, input logic [NF-1:0] p, input logic d, input logic u);
    exp_t e;
    @(posedge clk);
    #1;
    btn = b;
    cf  = c;
    e.name = n;
    e.r = r;
    e.p = p;
    e.d = d;
    e.u = u;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, ".req"}, 32'(requested_floor), 32'(e.r));
    chk({e.name, ".pend"}, 32'(pending), 32'(e.p));
    chk({e.name, ".door"}, 32'(door_open), 32'(e.d));
    chk({e.name, ".dir"}, 32'(dir_up), 32'(e.u));
  endtask
  task automatic rst_seq(input string n, input logic [NF-1:0] hold, input logic [3:0] c);
    @(posedge clk);
    #2;
    reset = 1'b0;
    btn = '1;
    cf = c;
    #1;
    chk({n, ".req"}, 32'(requested_floor), 32'd0);
    chk({n, ".pend"}, 32'(pending), 32'd0);
    chk({n, ".door"}, 32'(door_open), 32'd0);
    chk({n, ".dir"}, 32'(dir_up), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    btn = hold;
  endtask
  initial begin
    basic[0]  = '{10'h020, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1};
    basic[1]  = '{10'h000, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1};
    basic[2]  = '{10'h000, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1};
    basic[3]  = '{10'h000, 4'd0, 4'd0, 10'h020, 1'b0, 1'b1};
    basic[4]  = '{10'h000, 4'd5, 4'd5, 10'h020, 1'b0, 1'b1};
    basic[5]  = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b1, 1'b1};
    basic[6]  = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b1, 1'b1};
    basic[7]  = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b1, 1'b1};
    basic[8]  = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b1, 1'b1};
    basic[9]  = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b0, 1'b1};
    basic[10] = '{10'h000, 4'd5, 4'd5, 10'h000, 1'b0, 1'b1};
    rst_seq("por", 10'h008, 4'd0);
    step("rel0", 10'h008, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    step("rel1", 10'h008, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    step("rel2", 10'h008, 4'd0, 4'd0, 10'h008, 1'b0, 1'b1);
    step("rel3", 10'h008, 4'd0, 4'd3, 10'h008, 1'b0, 1'b1);
    rst_seq("r_basic", 10'h000, 4'd0);
    for (int k = 0; k < 11; k++)
      step($sformatf("basic%0d", k), basic[k].b, basic[k].c, basic[k].r, basic[k].p, basic[k].d, basic[k].u);
    rst_seq("r_route", 10'h000, 4'd2);
    step("route0", 10'h080, 4'd2, 4'd0, 10'h000, 1'b0, 1'b1);
    step("route1", 10'h000, 4'd2, 4'd0, 10'h000, 1'b0, 1'b1);
    step("route2", 10'h000, 4'd2, 4'd0, 10'h000, 1'b0, 1'b1);
    step("route3", 10'h000, 4'd2, 4'd0, 10'h080, 1'b0, 1'b1);
    step("route4", 10'h000, 4'd2, 4'd7, 10'h080, 1'b0, 1'b1);
    step("route5", 10'h010, 4'd2, 4'd7, 10'h080, 1'b0, 1'b1);
    step("route6", 10'h000, 4'd2, 4'd7, 10'h080, 1'b0, 1'b1);
    step("route7", 10'h000, 4'd2, 4'd7, 10'h080, 1'b0, 1'b1);
    step("route8", 10'h000, 4'd2, 4'd7, 10'h090, 1'b0, 1'b1);
    step("route9", 10'h002, 4'd2, 4'd4, 10'h090, 1'b0, 1'b1);
    step("route10", 10'h000, 4'd2, 4'd4, 10'h090, 1'b0, 1'b1);
    step("route11", 10'h000, 4'd2, 4'd4, 10'h090, 1'b0, 1'b1);
    step("route12", 10'h000, 4'd2, 4'd4, 10'h092, 1'b0, 1'b1);
    step("route13", 10'h000, 4'd2, 4'd4, 10'h092, 1'b0, 1'b1);
    rst_seq("r_scan", 10'h000, 4'd5);
    step("scan0", 10'h104, 4'd5, 4'd0, 10'h000, 1'b0, 1'b1);
    step("scan1", 10'h000, 4'd5, 4'd0, 10'h000, 1'b0, 1'b1);
    step("scan2", 10'h000, 4'd5, 4'd0, 10'h000, 1'b0, 1'b1);
    step("scan3", 10'h000, 4'd5, 4'd0, 10'h104, 1'b0, 1'b1);
    step("scan4", 10'h000, 4'd8, 4'd8, 10'h104, 1'b0, 1'b1);
    step("scan5", 10'h000, 4'd8, 4'd8, 10'h004, 1'b1, 1'b1);
    step("scan6", 10'h000, 4'd8, 4'd8, 10'h004, 1'b1, 1'b1);
    step("scan7", 10'h000, 4'd8, 4'd8, 10'h004, 1'b1, 1'b1);
    step("scan8", 10'h000, 4'd8, 4'd8, 10'h004, 1'b1, 1'b1);
    step("scan9", 10'h000, 4'd8, 4'd8, 10'h004, 1'b0, 1'b1);
    step("scan10", 10'h000, 4'd8, 4'd2, 10'h004, 1'b0, 1'b0);
    step("scan11", 10'h000, 4'd8, 4'd2, 10'h004, 1'b0, 1'b0);
    rst_seq("r_here", 10'h000, 4'd3);
    step("here0", 10'h008, 4'd3, 4'd0, 10'h000, 1'b0, 1'b1);
    step("here1", 10'h000, 4'd3, 4'd0, 10'h000, 1'b0, 1'b1);
    step("here2", 10'h000, 4'd3, 4'd0, 10'h000, 1'b0, 1'b1);
    step("here3", 10'h008, 4'd3, 4'd0, 10'h008, 1'b0, 1'b1);
    for (int k = 4; k < 10; k++)
      step($sformatf("here%0d", k), 10'h000, 4'd3, 4'd0, 10'h000, 1'b1, 1'b1);
    step("here10", 10'h000, 4'd3, 4'd0, 10'h000, 1'b0, 1'b1);
    step("here11", 10'h000, 4'd3, 4'd0, 10'h000, 1'b0, 1'b1);
    rst_seq("r_held", 10'h000, 4'd6);
    for (int k = 0; k < 11; k++)
      step($sformatf("held%0d", k), 10'h040, 4'd6, 4'd0,
           k == 3 ? 10'h040 : 10'h000, k >= 4 && k <= 7, 1'b1);
    rst_seq("r_oob", 10'h000, 4'd12);
    for (int k = 0; k < 7; k++)
      step($sformatf("oob%0d", k), k == 0 ? 10'h020 : 10'h000, 4'd12, 4'd0,
           k >= 3 ? 10'h020 : 10'h000, 1'b0, 1'b1);
    rst_seq("r_mid", 10'h000, 4'd0);
    step("mid0", 10'h050, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    step("mid1", 10'h000, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    step("mid2", 10'h000, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    step("mid3", 10'h000, 4'd0, 4'd0, 10'h050, 1'b0, 1'b1);
    step("mid4", 10'h000, 4'd0, 4'd4, 10'h050, 1'b0, 1'b1);
    step("mid5", 10'h000, 4'd0, 4'd4, 10'h050, 1'b0, 1'b1);
    rst_seq("midserv", 10'h000, 4'd0);
    step("post0", 10'h000, 4'd0, 4'd0, 10'h000, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
